// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: controller state encoding
// and the default operand width.
package serial_adder_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        FIN   = 2'b10
    } state_t;

endpackage

// File: rtl/serial_adder_fadd.sv
// One-bit full adder used by the serial adder for each bit position.
module fadd (
    input  logic C,
    input  logic B,
    input  logic A,
    output logic Carry,
    output logic Sum
);

    assign Sum   = A ^ B ^ C;
    assign Carry = (A & B) | (C & (A ^ B));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: adds two N-bit operands plus a carry-in one bit per
// clock, LSB first, through a single full-adder cell. The result is
// published on SUM/COUT together with a one-cycle DONE pulse.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int N = DEFAULT_WIDTH
) (
    input  logic         CLK,
    input  logic         RSTN,
    input  logic         START,
    input  logic [N-1:0] AIN,
    input  logic [N-1:0] BIN,
    input  logic         CIN,
    output logic         BUSY,
    output logic         DONE,
    output logic [N-1:0] SUM,
    output logic         COUT
);

    localparam int            CW   = $clog2(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);
    localparam logic [CW-1:0] ONE  = CW'(1);

    state_t state, state_next;

    logic [N-1:0]  a_sr;
    logic [N-1:0]  b_sr;
    logic [N-1:0]  psum;
    logic [N-1:0]  psum_next;
    logic          carry;
    logic [CW-1:0] cnt;
    logic          bit_sum;
    logic          bit_carry;
    logic          last_bit;
    logic          load;
    logic          unused_psum_lsb;

    fadd u_fadd (
        .C     (carry),
        .B     (b_sr[0]),
        .A     (a_sr[0]),
        .Carry (bit_carry),
        .Sum   (bit_sum)
    );

    assign psum_next = {bit_sum, psum[N-1:1]};
    assign last_bit  = (cnt == LAST);
    assign load      = START && ((state == IDLE) || (state == FIN));

    // The oldest slot of the partial sum is shifted out on the final bit
    // and never contributes to the result.
    assign unused_psum_lsb = psum[0];

    // State register; reset drops straight back to IDLE, aborting any add.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and status decode; FIN accepts a new START just like IDLE.
    always_comb begin
        state_next = state;
        BUSY       = 1'b0;
        DONE       = 1'b0;
        case (state)
            IDLE: begin
                if (START) begin
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                BUSY = 1'b1;
                if (last_bit) begin
                    state_next = FIN;
                end
            end
            FIN: begin
                DONE       = 1'b1;
                state_next = START ? SHIFT : IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Operand capture, one full-add step per SHIFT cycle, and result publish.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            a_sr  <= '0;
            b_sr  <= '0;
            psum  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            SUM   <= '0;
            COUT  <= 1'b0;
        end else if (load) begin
            a_sr  <= AIN;
            b_sr  <= BIN;
            carry <= CIN;
            cnt   <= '0;
        end else if (state == SHIFT) begin
            a_sr  <= {1'b0, a_sr[N-1:1]};
            b_sr  <= {1'b0, b_sr[N-1:1]};
            psum  <= psum_next;
            carry <= bit_carry;
            if (last_bit) begin
                SUM  <= psum_next;
                COUT <= bit_carry;
            end else begin
                cnt <= cnt + ONE;
            end
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder (N = 8): table-driven additions,
// held START, mid-operation reset, back-to-back starts and a long run
// with operand inputs scrambled while the adder is busy.
module tb_serial_adder;

    localparam int N = 8;

    typedef struct {
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic         cin;
        logic [N-1:0] sum;
        logic         cout;
    } vec_t;

    logic         CLK = 1'b0;
    logic         RSTN;
    logic         START;
    logic [N-1:0] AIN;
    logic [N-1:0] BIN;
    logic         CIN;
    logic         BUSY;
    logic         DONE;
    logic [N-1:0] SUM;
    logic         COUT;

    logic [N:0] sb[$];
    logic [N:0] monExp;
    int         numChecks = 0;
    int         numFails  = 0;

    vec_t vecs[8];

    serial_adder #(.N(N)) dut (
        .CLK   (CLK),
        .RSTN  (RSTN),
        .START (START),
        .AIN   (AIN),
        .BIN   (BIN),
        .CIN   (CIN),
        .BUSY  (BUSY),
        .DONE  (DONE),
        .SUM   (SUM),
        .COUT  (COUT)
    );

    // Free-running clock.
    always #5 CLK = ~CLK;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        numChecks++;
        if (actual !== expected) begin
            numFails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [N-1:0] a, input logic [N-1:0] b,
                                 input logic c, input logic [N:0] expected);
        START = 1'b1;
        AIN   = a;
        BIN   = b;
        CIN   = c;
        sb.push_back(expected);
    endtask

    task automatic waitDone(output int lat, output int busyCycles);
        bit seen;
        seen       = 1'b0;
        lat        = 0;
        busyCycles = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge CLK);
            lat++;
            START = 1'b0;
            if (BUSY) busyCycles++;
            if (DONE) seen = 1'b1;
        end
        if (!seen) checkOutput("done timeout", 32'd0, 32'd1);
    endtask

    // Scoreboard: every DONE pulse must match the oldest outstanding addition.
    always @(negedge CLK) begin
        if (DONE) begin
            if (sb.size() == 0) begin
                checkOutput("unexpected done", 32'd1, 32'd0);
            end else begin
                monExp = sb.pop_front();
                checkOutput("sum", 32'(SUM), 32'(monExp[N-1:0]));
                checkOutput("cout", 32'(COUT), 32'(monExp[N]));
            end
        end
    end

    // Guard against a hung run.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int lat;
        int busyCycles;
        int doneCount;
        logic [N-1:0] ra;
        logic [N-1:0] rb;
        logic         rc;
        bit           seen;

        vecs[0] = '{a: 8'h00, b: 8'h00, cin: 1'b0, sum: 8'h00, cout: 1'b0};
        vecs[1] = '{a: 8'hFF, b: 8'h01, cin: 1'b0, sum: 8'h00, cout: 1'b1};
        vecs[2] = '{a: 8'hFF, b: 8'hFF, cin: 1'b1, sum: 8'hFF, cout: 1'b1};
        vecs[3] = '{a: 8'h80, b: 8'h80, cin: 1'b0, sum: 8'h00, cout: 1'b1};
        vecs[4] = '{a: 8'h7F, b: 8'h01, cin: 1'b0, sum: 8'h80, cout: 1'b0};
        vecs[5] = '{a: 8'h55, b: 8'hAA, cin: 1'b1, sum: 8'h00, cout: 1'b1};
        vecs[6] = '{a: 8'h3C, b: 8'h0F, cin: 1'b1, sum: 8'h4C, cout: 1'b0};
        vecs[7] = '{a: 8'hC8, b: 8'h64, cin: 1'b0, sum: 8'h2C, cout: 1'b1};

        RSTN  = 1'b0;
        START = 1'b0;
        AIN   = '0;
        BIN   = '0;
        CIN   = 1'b0;

        #3;
        checkOutput("reset busy", 32'(BUSY), 32'd0);
        checkOutput("reset done", 32'(DONE), 32'd0);
        checkOutput("reset sum", 32'(SUM), 32'd0);
        checkOutput("reset cout", 32'(COUT), 32'd0);
        repeat (2) @(negedge CLK);
        RSTN = 1'b1;
        @(negedge CLK);

        $display("[TB] table-driven additions");
        for (int v = 0; v < 8; v++) begin
            applyStimulus(vecs[v].a, vecs[v].b, vecs[v].cin, {vecs[v].cout, vecs[v].sum});
            waitDone(lat, busyCycles);
            checkOutput("latency", 32'(lat), 32'(N + 1));
            checkOutput("busy cycles", 32'(busyCycles), 32'(N));
            @(negedge CLK);
        end

        $display("[TB] START held for four cycles");
        applyStimulus(8'hA5, 8'h5A, 1'b0, 9'h0FF);
        busyCycles = 0;
        doneCount  = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge CLK);
            AIN = 8'h00;
            BIN = 8'h33;
            if (i == 4) START = 1'b0;
            if (BUSY) busyCycles++;
            if (DONE) doneCount++;
        end
        checkOutput("held start busy cycles", 32'(busyCycles), 32'(N));
        checkOutput("held start done pulses", 32'(doneCount), 32'd1);

        $display("[TB] reset during SHIFT");
        applyStimulus(8'h3C, 8'h0F, 1'b0, 9'h04B);
        @(negedge CLK);
        START = 1'b0;
        repeat (3) @(negedge CLK);
        checkOutput("busy before abort", 32'(BUSY), 32'd1);
        #2;
        RSTN = 1'b0;
        #1;
        checkOutput("abort sum", 32'(SUM), 32'd0);
        checkOutput("abort cout", 32'(COUT), 32'd0);
        checkOutput("abort busy", 32'(BUSY), 32'd0);
        checkOutput("abort done", 32'(DONE), 32'd0);
        sb.delete();
        repeat (2) @(negedge CLK);
        RSTN = 1'b1;
        repeat (3) @(negedge CLK);
        checkOutput("sum after release", 32'(SUM), 32'd0);
        applyStimulus(8'h01, 8'h02, 1'b0, 9'h003);
        waitDone(lat, busyCycles);
        checkOutput("first start after reset latency", 32'(lat), 32'(N + 1));
        @(negedge CLK);

        $display("[TB] back-to-back start in FIN");
        applyStimulus(8'h12, 8'h34, 1'b0, 9'h046);
        waitDone(lat, busyCycles);
        checkOutput("prior done visible", 32'(DONE), 32'd1);
        applyStimulus(8'h10, 8'h20, 1'b0, 9'h030);
        waitDone(lat, busyCycles);
        checkOutput("back-to-back latency", 32'(lat), 32'(N + 1));
        @(negedge CLK);

        $display("[TB] randomised operands during SHIFT");
        for (int k = 0; k < 1000; k++) begin
            ra = N'($urandom);
            rb = N'($urandom);
            rc = 1'($urandom_range(0, 1));
            applyStimulus(ra, rb, rc, {1'b0, ra} + {1'b0, rb} + {{N{1'b0}}, rc});
            seen = 1'b0;
            lat  = 0;
            for (int i = 0; i < 40 && !seen; i++) begin
                @(negedge CLK);
                lat++;
                AIN = N'($urandom);
                BIN = N'($urandom);
                CIN = 1'($urandom_range(0, 1));
                if (BUSY) START = 1'($urandom_range(0, 1));
                else START = 1'b0;
                if (DONE) seen = 1'b1;
            end
            checkOutput("random latency", 32'(lat), 32'(N + 1));
        end
        START = 1'b0;
        repeat (3) @(negedge CLK);

        checkOutput("scoreboard empty", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
        $finish;
    end

endmodule
